// File: rtl/adc_pkg.sv
// Shared constants and helpers for the 8-channel ADC averager.
// Imported by adc_avg and adc_avg_lane.
package adc_pkg;

  localparam int NCH      = 8;
  localparam int DW       = 16;
  localparam int LOG2_MAX = 7;
  localparam int ACCW     = 23;
  localparam int LOG2_RST = 3;

  // Count value of the final sample of a block: N-1 = 2^log2 - 1.
  function automatic logic [LOG2_MAX-1:0] last_cnt(
    input logic [2:0] log2
  );
    logic [LOG2_MAX-1:0] ones;
    ones = '1;
    return ~(ones << log2);
  endfunction

endpackage

// File: rtl/adc_avg_lane.sv
// One averaging channel: accumulator, sample counter, result, flags.
// Ports: clk, rst, clr (flush partial block), log2 (depth), hit/din
// (sample for this lane), rd_hit (read of this lane), clr_ovr;
// outputs result, new_flag, ovr_flag.
module adc_avg_lane
  import adc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [2:0]           log2,
  input  logic                 hit,
  input  logic signed [DW-1:0] din,
  input  logic                 rd_hit,
  input  logic                 clr_ovr,
  output logic [DW-1:0]        result,
  output logic                 new_flag,
  output logic                 ovr_flag
);

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] shf;
  logic [LOG2_MAX-1:0]    cnt;
  logic                   upd;

  assign sum = acc + {{(ACCW-DW){din[DW-1]}}, din};
  assign shf = sum >>> log2;
  assign upd = hit && (cnt == last_cnt(log2));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (upd) begin
      acc <= '0;
      cnt <= '0;
    end else if (hit) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (upd) begin
      result <= shf[DW-1:0];
    end
  end

  // A read colliding with an update returns the old value, so the
  // fresh result stays unread and the collision is not an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      if (upd) begin
        new_flag <= 1'b1;
      end else if (rd_hit) begin
        new_flag <= 1'b0;
      end
      if (upd && new_flag && !rd_hit) begin
        ovr_flag <= 1'b1;
      end else if (clr_ovr) begin
        ovr_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_avg.sv
// 8-channel block averager of 2^log2 ADC samples with read-back port.
// Ports: clk, rst, s_valid/s_ch/s_data, cfg_wr/cfg_log2, rd_en/rd_addr,
// rd_data, new_flags, ovr_flags, clr_ovr.
module adc_avg
  import adc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  input  logic [2:0]     s_ch,
  input  logic [DW-1:0]  s_data,
  input  logic           cfg_wr,
  input  logic [2:0]     cfg_log2,
  input  logic           rd_en,
  input  logic [2:0]     rd_addr,
  output logic [DW-1:0]  rd_data,
  output logic [NCH-1:0] new_flags,
  output logic [NCH-1:0] ovr_flags,
  input  logic           clr_ovr
);

  logic [2:0]    log2_q;
  logic [DW-1:0] res [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      log2_q <= 3'(LOG2_RST);
    end else if (cfg_wr) begin
      log2_q <= cfg_log2;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    adc_avg_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (cfg_wr),
      .log2     (log2_q),
      .hit      (s_valid && !cfg_wr && (s_ch == 3'(i))),
      .din      (s_data),
      .rd_hit   (rd_en && (rd_addr == 3'(i))),
      .clr_ovr  (clr_ovr),
      .result   (res[i]),
      .new_flag (new_flags[i]),
      .ovr_flag (ovr_flags[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= res[rd_addr];
    end
  end

endmodule

// File: tb/tb_adc_avg.sv
// Directed self-checking bench for adc_avg.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_adc_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [2:0]  s_ch;
  logic [15:0] s_data;
  logic        cfg_wr;
  logic [2:0]  cfg_log2;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  new_flags;
  logic [7:0]  ovr_flags;
  logic        clr_ovr;

  int checks = 0;
  int errors = 0;

  adc_avg dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ch      (s_ch),
    .s_data    (s_data),
    .cfg_wr    (cfg_wr),
    .cfg_log2  (cfg_log2),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .new_flags (new_flags),
    .ovr_flags (ovr_flags),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [2:0] ch, input logic [15:0] d);
    s_valid = 1'b1;
    s_ch    = ch;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] l);
    cfg_wr   = 1'b1;
    cfg_log2 = l;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_ch = '0; s_data = '0;
    cfg_wr = 1'b0; cfg_log2 = '0; rd_en = 1'b0; rd_addr = '0;
    clr_ovr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rd", rd_data, 16'h0000);
    chk("rst_new", {8'h0, new_flags}, 16'h0000);
    chk("rst_ovr", {8'h0, ovr_flags}, 16'h0000);

    // default depth 8
    for (int i = 0; i < 7; i++) smp(3'd2, 16'h0100);
    chk("n8_partial_new", {8'h0, new_flags}, 16'h0000);
    smp(3'd2, 16'h0100);
    chk("n8_new", {8'h0, new_flags}, 16'h0004);
    rd(3'd2);
    chk("n8_rd", rd_data, 16'h0100);
    chk("n8_new_clr", {8'h0, new_flags}, 16'h0000);
    tick(); tick();
    chk("rd_hold", rd_data, 16'h0100);

    // depth 128, full-scale negative
    cfg(3'd7);
    for (int i = 0; i < 128; i++) smp(3'd0, 16'h8000);
    chk("n128_new", {8'h0, new_flags}, 16'h0001);
    rd(3'd0);
    chk("n128_rd", rd_data, 16'h8000);

    // depth 1, overrun and clear
    cfg(3'd0);
    smp(3'd7, 16'd5);
    chk("n1_new", {8'h0, new_flags}, 16'h0080);
    chk("n1_ovr0", {8'h0, ovr_flags}, 16'h0000);
    smp(3'd7, 16'hFFFD);
    chk("n1_ovr", {8'h0, ovr_flags}, 16'h0080);
    rd(3'd7);
    chk("n1_rd", rd_data, 16'hFFFD);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("clr_ovr", {8'h0, ovr_flags}, 16'h0000);

    // overrun coinciding with clr_ovr: set wins
    smp(3'd7, 16'd1);
    clr_ovr = 1'b1;
    smp(3'd7, 16'd2);
    clr_ovr = 1'b0;
    chk("ovr_set_wins", {8'h0, ovr_flags}, 16'h0080);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    rd(3'd7);
    chk("ovr_clr2", {8'h0, ovr_flags}, 16'h0000);

    // depth 2, floor rounding
    cfg(3'd1);
    smp(3'd1, 16'd3);
    smp(3'd1, 16'd4);
    rd(3'd1);
    chk("n2_pos", rd_data, 16'h0003);
    smp(3'd1, 16'hFFFD);
    smp(3'd1, 16'hFFFC);
    rd(3'd1);
    chk("n2_neg", rd_data, 16'hFFFC);

    // reconfigure discards partials and a coincident sample
    cfg(3'd3);
    for (int i = 0; i < 4; i++) smp(3'd5, 16'd100);
    s_valid = 1'b1; s_ch = 3'd5; s_data = 16'd1000;
    cfg(3'd1);
    s_valid = 1'b0;
    smp(3'd5, 16'd10);
    smp(3'd5, 16'd20);
    chk("cfg_new", {8'h0, new_flags}, 16'h0020);
    rd(3'd5);
    chk("cfg_flush", rd_data, 16'h000F);

    // read colliding with completion
    smp(3'd3, 16'd2);
    smp(3'd3, 16'd4);
    rd(3'd3);
    chk("col_pre", rd_data, 16'h0003);
    smp(3'd3, 16'd10);
    rd_en = 1'b1; rd_addr = 3'd3;
    smp(3'd3, 16'd20);
    rd_en = 1'b0;
    chk("col_old", rd_data, 16'h0003);
    chk("col_new", {8'h0, new_flags}, 16'h0008);
    chk("col_ovr", {8'h0, ovr_flags}, 16'h0000);
    rd(3'd3);
    chk("col_rd", rd_data, 16'h000F);

    // reset mid-accumulation restores depth 8 and drops partials
    for (int i = 0; i < 4; i++) smp(3'd6, 16'd8);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_rd", rd_data, 16'h0000);
    for (int i = 0; i < 7; i++) smp(3'd6, 16'd16);
    chk("rst2_partial", {8'h0, new_flags}, 16'h0000);
    smp(3'd6, 16'd16);
    rd(3'd6);
    chk("rst2_avg", rd_data, 16'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_avg.md
ADC_AVG -- requirements
Module: adc_avg

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port s_valid  input  1  one-cycle strobe; sample from ADC capture stage present.
REQ-004 SHALL have port s_ch  input  3  channel index of sample, 0..7, all valid.
REQ-005 SHALL have port s_data  input  16  sample, two's complement.
REQ-006 SHALL have port cfg_wr  input  1  one-cycle strobe; load averaging setting.
REQ-007 SHALL have port cfg_log2  input  3  averaging depth exponent, N = 2^cfg_log2 (1..128).
REQ-008 SHALL have port rd_en  input  1  one-cycle read strobe from bus-interface stage.
REQ-009 SHALL have port rd_addr  input  3  channel to read.
REQ-010 SHALL have port rd_data  output  16  registered averaged result of rd_addr channel.
REQ-011 SHALL have port new_flags  output  8  per-channel unread-result flags.
REQ-012 SHALL have port ovr_flags  output  8  per-channel sticky overrun flags.
REQ-013 SHALL have port clr_ovr  input  1  one-cycle strobe; clears all ovr_flags.

Function
REQ-014 SHALL keep per channel: 23-bit signed accumulator, 7-bit sample counter, 16-bit result register.
REQ-015 SHALL hold active depth register log2_q (3 bits); cfg_wr loads log2_q <= cfg_log2 on next edge.
REQ-016 SHALL on cfg_wr clear all accumulators and counters in the same edge; a s_valid in that cycle is discarded.
REQ-017 SHALL on s_valid (no cfg_wr) with counter < N-1: acc += sign-extended s_data, counter += 1.
REQ-018 SHALL on s_valid with counter == N-1: result <= (acc + s_data) arithmetic-shift-right log2_q, truncated to 16 bits; acc and counter cleared.
REQ-019 SHALL make result, new flag and rd-visible value update exactly 1 clk after the final sample's s_valid edge.
REQ-020 SHALL with log2_q = 0 pass each sample straight to result (N = 1, every sample completes).
REQ-021 SHALL never overflow the accumulator: 128 x (-32768) = -2^22 fits 23 bits signed.
REQ-022 SHALL on result update set new_flags[ch]; if new_flags[ch] already set, also set ovr_flags[ch].
REQ-023 SHALL on rd_en register rd_data <= result[rd_addr] (latency 1 clk) and clear new_flags[rd_addr].
REQ-024 SHALL, when rd_en and a result update hit the same channel in the same cycle, return the old result, leave new flag set, not set overrun.
REQ-025 SHALL hold rd_data stable between rd_en strobes.
REQ-026 SHALL, on clr_ovr coinciding with an overrun event, leave that ovr bit set (set wins).
REQ-027 SHALL have no backpressure: s_valid accepted every cycle, back-to-back, any channel order.

Reset
REQ-028 SHALL on rst clear accumulators, counters, results, rd_data (0x0000), new_flags, ovr_flags (0x00).
REQ-029 SHALL reset log2_q to 3 (N = 8).
REQ-030 SHALL give rst priority over all strobes; a reset mid-accumulation discards partial sums.

Structure
REQ-031 SHALL place NCH=8, DW=16, LOG2_MAX=7, ACCW=23, LOG2_RST=3 in shared package adc_pkg.
REQ-032 SHALL implement one channel (acc, counter, result, flags) as sub-module adc_avg_lane, instantiated 8 times.
REQ-033 SHALL contain no clock gating, no derived clocks, no combinational path s_data -> rd_data.

Verification
REQ-034 SHALL test: reset, then 8 samples 0x0100 on ch 2 -> 1 clk after 8th: new_flags=0x04; rd_en ch 2 -> rd_data 0x0100, new_flags=0x00.
REQ-035 SHALL test: cfg_log2=7, 128 samples 0x8000 on ch 0 -> result 0x8000, no accumulator wrap.
REQ-036 SHALL test: cfg_log2=0, samples 5,-3 on ch 7 unread -> second sets ovr_flags=0x80; clr_ovr -> 0x00.
REQ-037 SHALL test: log2=1, samples 3 then 4 on ch 1 -> result 0x0003 (floor of 3.5); samples -3,-4 -> 0xFFFC.
REQ-038 SHALL test: 4 samples on ch 5 (N=8), cfg_wr log2=1, then 2 samples 10,20 -> result 15, earlier partials gone.
REQ-039 SHALL test: rd_en ch 3 in the cycle ch 3 completes -> old value returned, new_flags[3] stays 1, ovr_flags[3] stays 0.
